// File: rtl/soc_pio_pkg.sv
// Shared definitions for the debounced push-button / switch PIO.
//
// Holds the slave register word addresses, the edge-detect mode encodings
// and a helper that folds rising/falling edge vectors into the captured
// edge vector for a given mode.
package soc_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_RSVD    = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_RAW     = 3'd4;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Works on a full 32-bit vector so every channel count can share it;
  // callers zero-extend and truncate back to their own width.
  function automatic logic [31:0] pick_edge(input logic [31:0] rise,
                                            input logic [31:0] fall,
                                            input int          edge_type);
    logic [31:0] sel;
    sel = rise;
    case (edge_type)
      EDGE_FALL: sel = fall;
      EDGE_ANY:  sel = rise | fall;
      default:   sel = rise;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/soc_buttons_debounced_pio_if.sv
// Avalon-MM slave bus bundle for the debounced PIO.
//
// Signals:
//   address    word address (3 bits)
//   chipselect slave select
//   write_n    write strobe, active-low
//   writedata  32-bit write data
//   readdata   32-bit registered read data
// Modports: master (interconnect side), slave (PIO side).
interface soc_buttons_debounced_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/pio_debounce_bit.sv
// Single-channel input conditioner: two-flop synchroniser followed by a
// debounce filter.
//
// Ports:
//   clk     system clock
//   reset   asynchronous reset, active-high
//   din     asynchronous button/switch input
//   raw     synchroniser output (two cycles behind din)
//   stable  debounced level; flips only after raw has disagreed with it
//           for DEBOUNCE_CYCLES consecutive cycles (0 = follow raw)
module pio_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 5000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic raw,
  output logic stable
);

  logic s1_q, s2_q;
  logic stable_q, stable_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      s1_q     <= din;
      s2_q     <= s1_q;
      stable_q <= stable_d;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_comb stable_d = s2_q;
    end else begin : g_filter
      localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] cnt_q, cnt_d;

      // The counter only runs while raw disagrees with stable, and is
      // cleared both on agreement and on the flip, so it can never wrap.
      always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (s2_q == stable_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          stable_d = s2_q;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end
    end
  endgenerate

  assign raw    = s2_q;
  assign stable = stable_q;

endmodule

// File: rtl/soc_buttons_debounced_pio.sv
// Avalon-MM input PIO for push-buttons and switches with debounce, edge
// capture and a maskable level interrupt.
//
// Ports:
//   clk      system clock
//   reset    asynchronous reset, active-high
//   s1       Avalon-MM slave (address, chipselect, write_n, writedata,
//            readdata); reads return the addressed register one cycle later
//   in_port  asynchronous button/switch inputs, WIDTH bits
//   irq      level interrupt, high while any unmasked capture bit is set
//
// Registers: 0 debounced data (RO), 1 reserved, 2 irqmask (RW),
// 3 edgecapture (write clears), 4 synchroniser output (RO), 5..7 read 0.
module soc_buttons_debounced_pio
  import soc_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 5000,
  parameter int EDGE_TYPE       = 0,
  parameter int BIT_CLEAR       = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  soc_buttons_debounced_pio_if.slave  s1,
  input  logic [WIDTH-1:0]            in_port,
  output logic                        irq
);

  generate
    if (EDGE_TYPE < EDGE_RISE || EDGE_TYPE > EDGE_ANY) begin : g_bad_edge_type
      $error("soc_buttons_debounced_pio: EDGE_TYPE must be 0, 1 or 2");
    end
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("soc_buttons_debounced_pio: WIDTH must be 1..32");
    end
  endgenerate

  logic [WIDTH-1:0] raw_w, stable_w;
  logic [WIDTH-1:0] rise_w, fall_w, edge_w;
  logic [WIDTH-1:0] clr_w;
  logic             wr_w;

  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [31:0]      rd_q, rd_d;
  logic             irq_q, irq_d;

  // Upper write-data bits have no destination when WIDTH < 32.
  logic unused_wd;
  assign unused_wd = ^s1.writedata;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      pio_debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .clk   (clk),
        .reset (reset),
        .din   (in_port[gi]),
        .raw   (raw_w[gi]),
        .stable(stable_w[gi])
      );
    end
  endgenerate

  assign wr_w   = s1.chipselect & ~s1.write_n;
  assign rise_w = stable_w & ~prev_q;
  assign fall_w = ~stable_w & prev_q;
  assign edge_w = WIDTH'(pick_edge(32'(rise_w), 32'(fall_w), EDGE_TYPE));

  always_comb begin
    clr_w  = '0;
    prev_d = stable_w;
    mask_d = mask_q;
    rd_d   = '0;

    if (wr_w && s1.address == ADDR_EDGECAP) begin
      clr_w = (BIT_CLEAR != 0) ? s1.writedata[WIDTH-1:0] : {WIDTH{1'b1}};
    end
    if (wr_w && s1.address == ADDR_IRQMASK) begin
      mask_d = s1.writedata[WIDTH-1:0];
    end

    // OR-ing the edge after the clear means a clear can never swallow an
    // edge arriving in the same cycle.
    cap_d = (cap_q & ~clr_w) | edge_w;

    // Registered from flops only, so no input reaches irq combinationally.
    irq_d = |(cap_q & mask_q);

    case (s1.address)
      ADDR_DATA:    rd_d[WIDTH-1:0] = stable_w;
      ADDR_IRQMASK: rd_d[WIDTH-1:0] = mask_q;
      ADDR_EDGECAP: rd_d[WIDTH-1:0] = cap_q;
      ADDR_RAW:     rd_d[WIDTH-1:0] = raw_w;
      default:      rd_d            = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
      cap_q  <= '0;
      mask_q <= '0;
      rd_q   <= '0;
      irq_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      cap_q  <= cap_d;
      mask_q <= mask_d;
      rd_q   <= rd_d;
      irq_q  <= irq_d;
    end
  end

  assign s1.readdata = rd_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_soc_buttons_debounced_pio.sv
// Scoreboard bench for soc_buttons_debounced_pio. Two instances share one
// stimulus stream: dut0 (rising edge, bit clear) and dut1 (any edge,
// write clears all). A reference model predicts readdata and irq after
// every clock edge and pushes them into a queue; a monitor pops and
// compares on the falling edge.
module tb_soc_buttons_debounced_pio;
  localparam int W = 4;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [W-1:0]  in_port = '0;
  logic          irq0, irq1;

  soc_buttons_debounced_pio_if bus0();
  soc_buttons_debounced_pio_if bus1();

  assign bus0.address    = address;
  assign bus0.chipselect = chipselect;
  assign bus0.write_n    = write_n;
  assign bus0.writedata  = writedata;
  assign bus1.address    = address;
  assign bus1.chipselect = chipselect;
  assign bus1.write_n    = write_n;
  assign bus1.writedata  = writedata;

  soc_buttons_debounced_pio #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0), .BIT_CLEAR(1)
  ) dut0 (
    .clk(clk), .reset(reset), .s1(bus0.slave), .in_port(in_port), .irq(irq0)
  );

  soc_buttons_debounced_pio #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2), .BIT_CLEAR(0)
  ) dut1 (
    .clk(clk), .reset(reset), .s1(bus1.slave), .in_port(in_port), .irq(irq1)
  );

  always #5 clk = ~clk;

  // Reference model state. hist[0] is the current synchronised sample,
  // hist[D-1] the oldest one still inside the debounce window.
  typedef struct packed {
    logic [D-1:0][W-1:0] hist;
    logic [W-1:0]        s1, s2, stable, prev, cap, mask;
    logic [31:0]         rd;
    logic                irq;
  } model_t;

  typedef struct packed {
    logic [31:0] rd0, rd1;
    logic        irq0, irq1;
  } exp_t;

  model_t m0 = '0;
  model_t m1 = '0;
  exp_t   expq[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     cyc      = 0;

  // A channel flips once every synchronised sample in the last D cycles
  // disagreed with its current stable level.
  function automatic model_t step(model_t o, int et, int bc, logic rst,
                                  logic [W-1:0] din, logic [2:0] a,
                                  logic wr, logic [31:0] wd);
    model_t       n;
    logic [W-1:0] rise, fall, ev, clr;
    bit           all_diff;
    if (rst) return '0;
    n    = o;
    n.s1 = din;
    n.s2 = o.s1;
    for (int b = 0; b < W; b++) begin
      all_diff = 1'b1;
      for (int j = 0; j < D; j++)
        if (o.hist[j][b] == o.stable[b]) all_diff = 1'b0;
      if (all_diff) n.stable[b] = ~o.stable[b];
    end
    n.hist = {o.hist[D-2:0], n.s2};
    rise   = o.stable & ~o.prev;
    fall   = ~o.stable & o.prev;
    ev     = (et == 0) ? rise : (et == 1) ? fall : (rise | fall);
    n.prev = o.stable;
    clr    = (wr && a == 3'd3) ? ((bc != 0) ? wd[W-1:0] : {W{1'b1}}) : '0;
    n.cap  = (o.cap & ~clr) | ev;
    if (wr && a == 3'd2) n.mask = wd[W-1:0];
    n.irq  = |(o.cap & o.mask);
    case (a)
      3'd0:    n.rd = 32'(o.stable);
      3'd2:    n.rd = 32'(o.mask);
      3'd3:    n.rd = 32'(o.cap);
      3'd4:    n.rd = 32'(o.s2);
      default: n.rd = '0;
    endcase
    return n;
  endfunction

  // One clock: advance the model with the inputs seen at this edge, queue
  // the prediction, and return 2 ns after the falling edge so the monitor
  // has sampled before inputs move.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    m0 = step(m0, 0, 1, reset, in_port, address, chipselect & ~write_n, writedata);
    m1 = step(m1, 2, 0, reset, in_port, address, chipselect & ~write_n, writedata);
    e.rd0  = m0.rd;
    e.rd1  = m1.rd;
    e.irq0 = m0.irq;
    e.irq1 = m1.irq;
    expq.push_back(e);
    cyc++;
    @(negedge clk);
    #2;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, got, want);
    end
  endtask

  // Monitor: readdata and irq are presented every cycle, one edge after
  // the prediction was queued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("dut0.readdata", bus0.readdata, e.rd0);
        check("dut0.irq", 32'(irq0), 32'(e.irq0));
        check("dut1.readdata", bus1.readdata, e.rd1);
        check("dut1.irq", 32'(irq1), 32'(e.irq1));
      end
    end
  end

  initial begin
    int idx, hold, r;

    // Reset, then read each implemented register.
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    address = 3'd0; tick();
    address = 3'd2; tick();
    address = 3'd3; tick();
    address = 3'd4; tick();

    // Bit0 press held long enough to debounce.
    address = 3'd0;
    in_port = 4'b0001;
    repeat (10) tick();
    address = 3'd3;
    repeat (2) tick();
    wr_reg(3'd2, 32'h1);
    address = 3'd2;
    repeat (3) tick();

    // Short glitch on bit1, then a pulse just long enough.
    address = 3'd3;
    in_port[1] = 1'b1; repeat (3) tick();
    in_port[1] = 1'b0; repeat (10) tick();
    in_port[1] = 1'b1; repeat (4) tick();
    in_port[1] = 1'b0; repeat (10) tick();

    // Clear bit0 only, then clear bit1 in the cycle its rising edge lands.
    wr_reg(3'd3, 32'h1);
    address = 3'd3;
    repeat (2) tick();
    in_port[1] = 1'b1;
    repeat (6) tick();
    wr_reg(3'd3, 32'h2);
    address = 3'd3;
    repeat (3) tick();

    // Press and release bit2.
    wr_reg(3'd3, 32'h0);
    address = 3'd3;
    in_port[2] = 1'b1; repeat (8) tick();
    wr_reg(3'd3, 32'h0);
    address = 3'd3;
    in_port[2] = 1'b0; repeat (8) tick();

    // Reset while bit3 is mid-debounce; inputs stay high through reset.
    in_port[3] = 1'b1;
    repeat (4) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    address = 3'd0; repeat (6) tick();
    address = 3'd3; repeat (6) tick();

    // Randomised phase.
    for (int c = 0; c < 500; c += hold) begin
      hold = $urandom_range(1, 7);
      if ($urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, W - 1);
        in_port[idx] = ~in_port[idx];
      end
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1; tick(); reset = 1'b0;
      end
      for (int h = 0; h < hold; h++) begin
        r = $urandom_range(0, 9);
        if (r < 2) begin
          wr_reg(3'($urandom_range(0, 7)), $urandom);
        end else begin
          address = 3'($urandom_range(0, 7));
          tick();
        end
      end
    end

    repeat (2) tick();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
